// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags, optional FWFT.
// Latency: write visible (empty low) 1 cycle after the accepting edge; FWFT=0 read data 1 cycle after accepted r_en, FWFT=1 head word shown combinationally.
// Backpressure: writes while full and reads while empty are dropped and latch overflow/underflow until clr_err.
module fifo_sync_flags #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         w_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         r_en,
    input  logic                         clr_err,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Accept decisions use the flags as they stand before the edge; a read at full frees no slot for a same-cycle write.
    assign wr_ok = w_en && !full;
    assign rd_ok = r_en && !empty;

    // Status flags are pure decodes of the registered count, so they only move on clock edges or reset.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Storage array; deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy; pointers are exactly AW bits so they wrap at DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky error flags; a new illegal request in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;

            // Registered read port: load the head word on an accepted read, otherwise hold.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign data_out = dout_q;
        end else begin : g_fwft
            // Head word falls through while data is present; zero when empty so stale entries never leak out.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end
    endgenerate

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised single-clock FIFO: the next generation of the team's synchronous FIFO. Beyond the basic full/empty buffer it adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through read mode. It sits between a producer and a consumer in the same clock domain and is the standard buffering element for streaming datapaths.

## Interface
- DEPTH, 8: number of entries; power of two, ≥ 2.
- DATA_WIDTH, 8: word width in bits.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0: 0 = registered read (standard); 1 = first-word-fall-through.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request.
- clr_err  in  1  synchronous clear of overflow/underflow.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH×DATA_WIDTH array, not reset. Write and read pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0 naturally.
- Write accepted iff w_en && !full (full sampled before the edge): mem[wr_ptr] ← data_in, wr_ptr +1.
- Read accepted iff r_en && !empty: rd_ptr +1.
- count: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- Both requests at full: read accepted, write rejected (overflow sets); count becomes DEPTH-1. Both at empty: write accepted, read rejected (underflow sets); count becomes 1. No write-to-read bypass.
- FWFT=0: data_out is a register loaded with mem[rd_ptr] on an accepted read; otherwise it holds.
- FWFT=1: data_out = mem[rd_ptr] combinationally while !empty and 0 while empty; an accepted read advances to the next word.
- Flags are combinational decodes of the registered count only; there is no separate flag state.
- overflow set on w_en && full; underflow set on r_en && empty. Both stay set until clr_err; when set and clr_err coincide, set wins.
- Reset (asynchronous, any time, including mid-transfer): pointers 0, count 0, data_out 0, overflow 0, underflow 0, giving empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are don't-care afterwards.

## Timing
- Write-to-empty deassert: 1 cycle (empty low after the edge that accepts the write).
- FWFT=0 read latency: data_out valid 1 cycle after the edge accepting r_en.
- FWFT=1: the head word is visible on data_out in the same cycle empty drops.
- All flags and count change only on clock edges (or asynchronously at reset). They are stable for the whole cycle.
- Sustained throughput: 1 write and 1 read per cycle.

## Test plan
- Reset, then write 1..8 on consecutive cycles (DEPTH=8) -> count 1..8; almost_full first high at count 6; full high after the 8th write; empty low after the first write.
- Ninth write 0xAA while full -> rejected, count stays 8, overflow=1; then read 8 words (FWFT=0) -> data_out sequence 1..8, each 1 cycle after its r_en; then empty=1.
- Read while empty -> underflow=1, count stays 0; clr_err pulse -> overflow=underflow=0; a cycle with clr_err and a new illegal read -> underflow stays 1.
- Fill to 4, then simultaneous w_en/r_en for 20 cycles with incrementing data -> count constant 4, data in order across pointer wrap, no error flags.
- FWFT=1: write 0x5C into an empty FIFO -> data_out=0x5C on the cycle empty drops; r_en -> empty=1, data_out=0.
- Assert rst_n=0 mid-cycle with count=5 -> outputs return to reset values immediately without a clock edge; subsequent writes start at address 0.
